alu_seq_unit: RTL and testbench

//  Parametrised, registered successor to the single-cycle EXE-stage ALU. It executes the same

---
 rtl/alu_seq_unit.sv | 185 ++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// Registered EXE-stage ALU with valid/ready handshake and an iterative shift-add multiplier.
// Single-cycle ops complete in one cycle; MUL takes WIDTH/MUL_STEP BUSY cycles.
module alu_seq_unit #(
  parameter int WIDTH    = 32,
  parameter int CMD_W    = 4,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CMD_W-1:0] alu_command,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       status_register,
  output logic             busy
);

  localparam int STEPS = WIDTH / MUL_STEP;
  localparam int CNT_W = $clog2(STEPS + 1);

  localparam logic [CMD_W-1:0] OP_MOV = CMD_W'(4'b0001);
  localparam logic [CMD_W-1:0] OP_ADD = CMD_W'(4'b0010);
  localparam logic [CMD_W-1:0] OP_ADC = CMD_W'(4'b0011);
  localparam logic [CMD_W-1:0] OP_SUB = CMD_W'(4'b0100);
  localparam logic [CMD_W-1:0] OP_SBC = CMD_W'(4'b0101);
  localparam logic [CMD_W-1:0] OP_AND = CMD_W'(4'b0110);
  localparam logic [CMD_W-1:0] OP_ORR = CMD_W'(4'b0111);
  localparam logic [CMD_W-1:0] OP_EOR = CMD_W'(4'b1000);
  localparam logic [CMD_W-1:0] OP_MVN = CMD_W'(4'b1001);
  localparam logic [CMD_W-1:0] OP_LDR = CMD_W'(4'b1010);
  localparam logic [CMD_W-1:0] OP_MUL = CMD_W'(4'b1011);
  localparam logic [CMD_W-1:0] OP_CMP = CMD_W'(4'b1100);
  localparam logic [CMD_W-1:0] OP_TST = CMD_W'(4'b1110);

  localparam logic [2:0] K_LOGIC = 3'd0;
  localparam logic [2:0] K_ADD   = 3'd1;
  localparam logic [2:0] K_SUB   = 3'd2;
  localparam logic [2:0] K_ADDR  = 3'd3;
  localparam logic [2:0] K_BAD   = 3'd4;
  localparam logic [2:0] K_MUL   = 3'd5;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  // Sum of the multiplicand shifted by each set bit of one multiplier digit.
  function automatic logic [WIDTH-1:0] mul_partial(input logic [WIDTH-1:0] a,
                                                   input logic [MUL_STEP-1:0] b);
    logic [WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (b[i]) p = p + (a << i);
      else      p = p;
    end
    return p;
  endfunction

  state_t           r_state;
  logic             r_valid, r_busy, r_cin;
  logic [WIDTH-1:0] r_out, r_mul_a, r_mul_b, r_acc;
  logic [3:0]       r_status;
  logic [CNT_W-1:0] r_cnt;

  logic             w_ci_add, w_ci_sub, w_accept, w_z, w_n;
  logic [WIDTH:0]   w_add, w_sub;
  logic [WIDTH-1:0] w_res, w_acc_next;
  logic [2:0]       w_kind;
  logic [3:0]       w_flags;

  // Subtraction is A + ~B + carry, so the carry out is the inverted borrow.
  assign w_ci_add   = (alu_command == OP_ADC) ? cin : 1'b0;
  assign w_ci_sub   = (alu_command == OP_SBC) ? cin : 1'b1;
  assign w_add      = {1'b0, alu_in1} + {1'b0, alu_in2}  + (WIDTH+1)'(w_ci_add);
  assign w_sub      = {1'b0, alu_in1} + {1'b0, ~alu_in2} + (WIDTH+1)'(w_ci_sub);
  assign w_acc_next = r_acc + mul_partial(r_mul_a, r_mul_b[MUL_STEP-1:0]);
  assign w_accept   = in_valid & in_ready;
  assign in_ready   = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);

  // Opcode decode: select result and flag class.
  always_comb begin
    w_kind = K_BAD;
    w_res  = '0;
    case (alu_command)
      OP_MOV:                 begin w_kind = K_LOGIC; w_res = alu_in2;            end
      OP_MVN:                 begin w_kind = K_LOGIC; w_res = ~alu_in2;           end
      OP_AND, OP_TST:         begin w_kind = K_LOGIC; w_res = alu_in1 & alu_in2;  end
      OP_ORR:                 begin w_kind = K_LOGIC; w_res = alu_in1 | alu_in2;  end
      OP_EOR:                 begin w_kind = K_LOGIC; w_res = alu_in1 ^ alu_in2;  end
      OP_ADD, OP_ADC:         begin w_kind = K_ADD;   w_res = w_add[WIDTH-1:0];   end
      OP_SUB, OP_SBC, OP_CMP: begin w_kind = K_SUB;   w_res = w_sub[WIDTH-1:0];   end
      OP_LDR:                 begin w_kind = K_ADDR;  w_res = w_add[WIDTH-1:0];   end
      OP_MUL:                 begin w_kind = K_MUL;   w_res = '0;                 end
      default:                begin w_kind = K_BAD;   w_res = '0;                 end
    endcase
  end

  // Flag generation {Z,C,N,V} for the single-cycle result.
  always_comb begin
    w_z = (w_res == '0);
    w_n = w_res[WIDTH-1];
    case (w_kind)
      K_LOGIC: w_flags = {w_z, cin, w_n, 1'b0};
      K_ADD:   w_flags = {w_z, w_add[WIDTH], w_n,
                          (alu_in1[WIDTH-1] == alu_in2[WIDTH-1]) & (w_n != alu_in1[WIDTH-1])};
      K_SUB:   w_flags = {w_z, w_sub[WIDTH], w_n,
                          (alu_in1[WIDTH-1] != alu_in2[WIDTH-1]) & (w_n != alu_in1[WIDTH-1])};
      K_ADDR:  w_flags = 4'b0000;
      K_BAD:   w_flags = 4'b1000;
      default: w_flags = 4'b0000;
    endcase
  end

  // Control FSM, multiplier datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_out    <= '0;
      r_status <= 4'b0000;
      r_cnt    <= '0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_acc    <= '0;
      r_cin    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            if (w_kind == K_MUL) begin
              r_state <= S_BUSY;
              r_cnt   <= CNT_W'(STEPS);
              r_mul_a <= alu_in1;
              r_mul_b <= alu_in2;
              r_acc   <= '0;
              r_cin   <= cin;
              r_valid <= 1'b0;
              r_busy  <= 1'b1;
            end else begin
              r_state  <= S_DONE;
              r_out    <= w_res;
              r_status <= w_flags;
              r_valid  <= 1'b1;
              r_busy   <= 1'b0;
            end
          end else if ((r_state == S_DONE) && out_ready) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end else begin
            r_state <= r_state;
          end
        end
        S_BUSY: begin
          r_cnt   <= r_cnt - CNT_W'(1);
          r_acc   <= w_acc_next;
          r_mul_a <= r_mul_a << MUL_STEP;
          r_mul_b <= r_mul_b >> MUL_STEP;
          if (r_cnt == CNT_W'(1)) begin
            r_state  <= S_DONE;
            r_out    <= w_acc_next;
            r_status <= {(w_acc_next == '0), r_cin, w_acc_next[WIDTH-1], 1'b0};
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_state <= S_BUSY;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid       = r_valid;
  assign alu_out         = r_out;
  assign status_register = r_status;
  assign busy            = r_busy;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: a 32-bit/step-1 instance and an 8-bit/step-4 instance,
// with a scoreboard queue per instance popped whenever a result is consumed.
module tb_alu_seq_unit;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] eo;
    logic [3:0]  es;
  } vec_t;

  typedef struct {
    logic [31:0] o;
    logic [3:0]  s;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        v32 = 1'b0, rdy32, cin32 = 1'b0, ov32, ordy32 = 1'b1, busy32;
  logic [3:0]  cmd32 = 4'd0, st32;
  logic [31:0] a32 = 32'd0, b32 = 32'd0, out32;

  logic        v8 = 1'b0, rdy8, cin8 = 1'b0, ov8, ordy8 = 1'b1, busy8;
  logic [3:0]  cmd8 = 4'd0, st8;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0, out8;

  int checks = 0;
  int failures = 0;
  exp_t q32[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(32), .CMD_W(4), .MUL_STEP(1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .alu_command(cmd32),
    .alu_in1(a32), .alu_in2(b32), .cin(cin32), .out_valid(ov32), .out_ready(ordy32),
    .alu_out(out32), .status_register(st32), .busy(busy32));

  alu_seq_unit #(.WIDTH(8), .CMD_W(4), .MUL_STEP(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .alu_command(cmd8),
    .alu_in1(a8), .alu_in2(b8), .cin(cin8), .out_valid(ov8), .out_ready(ordy8),
    .alu_out(out8), .status_register(st8), .busy(busy8));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Scoreboards: compare every consumed result against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && ov32 && ordy32) begin
      if (q32.size() == 0) check("sb32_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q32.pop_front();
        check("sb32_out", out32, e.o);
        check("sb32_status", {28'd0, st32}, {28'd0, e.s});
      end
    end
    if (!rst && ov8 && ordy8) begin
      if (q8.size() == 0) check("sb8_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        check("sb8_out", {24'd0, out8}, e.o);
        check("sb8_status", {28'd0, st8}, {28'd0, e.s});
      end
    end
  end

  task automatic issue32(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic [31:0] eo, input logic [3:0] es,
                         input bit push);
    bit acc = 1'b0;
    int n = 0;
    v32 = 1'b1; cmd32 = c; a32 = a; b32 = b; cin32 = ci;
    while (!acc && n < 100) begin
      @(negedge clk); acc = rdy32;
      @(posedge clk); #1; n++;
    end
    v32 = 1'b0;
    if (!acc) check("issue32_timeout", 32'd0, 32'd1);
    else if (push) q32.push_back('{eo, es});
  endtask

  task automatic issue8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [7:0] eo, input logic [3:0] es);
    bit acc = 1'b0;
    int n = 0;
    v8 = 1'b1; cmd8 = c; a8 = a; b8 = b; cin8 = ci;
    while (!acc && n < 100) begin
      @(negedge clk); acc = rdy8;
      @(posedge clk); #1; n++;
    end
    v8 = 1'b0;
    if (!acc) check("issue8_timeout", 32'd0, 32'd1);
    else q8.push_back('{{24'd0, eo}, es});
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
      @(negedge clk); n++;
    end
    check("drain", q32.size() + q8.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t vecs[$];
    int n, nb, bad;

    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int n, nb, bad;

    vecs = '{
      '{4'b0100, 32'd5,          32'd5,          1'b0, 32'h0000_0000, 4'b1100},
      '{4'b0100, 32'd3,          32'd5,          1'b0, 32'hFFFF_FFFE, 4'b0010},
      '{4'b0101, 32'd5,          32'd2,          1'b0, 32'h0000_0002, 4'b0100},
      '{4'b0101, 32'd5,          32'd2,          1'b1, 32'h0000_0003, 4'b0100},
      '{4'b0011, 32'hFFFF_FFFF, 32'd0,          1'b1, 32'h0000_0000, 4'b1100},
      '{4'b0010, 32'hFFFF_FFFF, 32'd1,          1'b1, 32'h0000_0000, 4'b1100},
      '{4'b0010, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 4'b1101},
      '{4'b0100, 32'h8000_0000, 32'd1,          1'b0, 32'h7FFF_FFFF, 4'b0101},
      '{4'b0001, 32'h1234_5678, 32'h0000_00A5, 1'b1, 32'h0000_00A5, 4'b0100},
      '{4'b1001, 32'd0,          32'd0,          1'b0, 32'hFFFF_FFFF, 4'b0010},
      '{4'b0110, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 32'h0000_0000, 4'b1000},
      '{4'b0111, 32'h8000_0000, 32'd1,          1'b1, 32'h8000_0001, 4'b0110},
      '{4'b1000, 32'h0000_00FF, 32'h0000_000F, 1'b0, 32'h0000_00F0, 4'b0000},
      '{4'b1110, 32'h0000_00FF, 32'h0000_0100, 1'b1, 32'h0000_0000, 4'b1100},
      '{4'b1100, 32'd3,          32'd5,          1'b0, 32'hFFFF_FFFE, 4'b0010},
      '{4'b1010, 32'h0000_1000, 32'h0000_0024, 1'b1, 32'h0000_1024, 4'b0000},
      '{4'b1010, 32'hFFFF_FFFF, 32'd1,          1'b0, 32'h0000_0000, 4'b0000},
      '{4'b0000, 32'd7,          32'd9,          1'b1, 32'h0000_0000, 4'b1000},
      '{4'b1111, 32'd7,          32'd9,          1'b0, 32'h0000_0000, 4'b1000},
      '{4'b1011, 32'h1234_5678, 32'd0,          1'b1, 32'h0000_0000, 4'b1100},
      '{4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 4'b0000},
      '{4'b1011, 32'h8000_0000, 32'd1,          1'b0, 32'h8000_0000, 4'b0010},
      '{4'b1011, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0000, 4'b1000}
    };

    // Reset and idle outputs
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, ov32}, 32'd0);
    check("rst_busy", {31'd0, busy32}, 32'd0);
    check("rst_alu_out", out32, 32'd0);
    check("rst_status", {28'd0, st32}, 32'd0);
    check("rst_in_ready", {31'd0, rdy32}, 32'd1);
    @(posedge clk); #1;

    // Single-cycle latency of the first ADD
    issue32(4'b0010, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 4'b0011, 1'b1);
    @(negedge clk);
    check("add_latency_valid", {31'd0, ov32}, 32'd1);
    check("add_latency_out", out32, 32'h8000_0000);
    @(posedge clk); #1;

    // Table, issued back-to-back
    for (int i = 0; i < vecs.size(); i++)
      issue32(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].eo, vecs[i].es, 1'b1);
    drain();

    // MUL: 32 busy cycles, in_ready low, junk command ignored until DONE
    issue32(4'b1011, 32'h0001_0003, 32'd7, 1'b0, 32'h0007_0015, 4'b0000, 1'b1);
    v32 = 1'b1; cmd32 = 4'b0001; a32 = 32'd0; b32 = 32'h55; cin32 = 1'b0;
    n = 0; nb = 0; bad = 0;
    do begin
      @(negedge clk); n++;
      if (busy32) nb++;
      if (busy32 && (rdy32 || ov32)) bad++;
    end while (!ov32 && n < 100);
    check("mul_valid_cycle", n, 32'd33);
    check("mul_busy_cycles", nb, 32'd32);
    check("mul_busy_ready_low", bad, 32'd0);
    check("mul_done_ready", {31'd0, rdy32}, 32'd1);
    @(posedge clk); #1;
    v32 = 1'b0;
    q32.push_back('{32'h55, 4'b0000});
    drain();

    // Stall for 5 cycles, then consume and accept MOV 0xA5 together
    ordy32 = 1'b0;
    issue32(4'b0010, 32'd1, 32'd2, 1'b0, 32'd3, 4'b0000, 1'b1);
    v32 = 1'b1; cmd32 = 4'b0001; a32 = 32'd0; b32 = 32'hA5; cin32 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, ov32}, 32'd1);
      check("stall_out", out32, 32'd3);
      check("stall_status", {28'd0, st32}, 32'd0);
      check("stall_in_ready", {31'd0, rdy32}, 32'd0);
    end
    @(posedge clk); #1;
    ordy32 = 1'b1;
    @(negedge clk);
    check("release_in_ready", {31'd0, rdy32}, 32'd1);
    @(posedge clk); #1;
    v32 = 1'b0;
    q32.push_back('{32'hA5, 4'b0000});
    @(negedge clk);
    check("release_mov_out", out32, 32'hA5);
    drain();

    // 8-bit instance, 4 multiplier bits per cycle
    issue8(4'b0011, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b1100);
    issue8(4'b0100, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0101);
    issue8(4'b1011, 8'h0F, 8'h0F, 1'b0, 8'hE1, 4'b0010);
    issue8(4'b1011, 8'h10, 8'h10, 1'b0, 8'h00, 4'b1000);
    n = 0; nb = 0;
    do begin
      @(negedge clk); n++;
      if (busy8) nb++;
    end while (!ov8 && n < 100);
    check("mul8_valid_cycle", n, 32'd3);
    check("mul8_busy_cycles", nb, 32'd2);
    drain();

    // Reset in the middle of a MUL
    issue32(4'b1011, 32'h0001_0003, 32'd7, 1'b0, 32'd0, 4'b0000, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", {31'd0, busy32}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, ov32}, 32'd0);
    check("midrst_busy", {31'd0, busy32}, 32'd0);
    check("midrst_alu_out", out32, 32'd0);
    check("midrst_status", {28'd0, st32}, 32'd0);
    check("midrst_in_ready", {31'd0, rdy32}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    issue32(4'b0100, 32'd5, 32'd5, 1'b0, 32'd0, 4'b1100, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
